// File: rtl/device_burst_controller.sv
// -----------------------------------------------------------------------------
// device_burst_controller
//
// Runs multi-beat read or write bursts against a memory with a ready
// handshake. The beat address increments automatically and wraps modulo
// 2^ADDR_W. Each beat waits for mem_ready. If mem_ready does not arrive
// within TIMEOUT strobe cycles, the burst is abandoned with an error pulse.
// Every output is driven from a register.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start_en        burst request (only honoured in IDLE)
//   wr_en           burst mode at start: 1 = write, 0 = read
//   start_addr      first beat address
//   burst_len       beats requested (0 -> 1, clamped to MAX_BURST)
//   wr_data         write data, sampled on each entry to ACCESS
//   mem_ready       memory beat-complete handshake
//   mem_rdata       memory read data, valid with mem_ready
//   dc_cs_out       chip select, active low
//   dc_rd_out       read strobe
//   dc_wr_out       write strobe
//   dc_addr_out     current beat address
//   dc_wdata_out    write data presented to memory
//   dc_rdata_out    last captured read data (held until next capture/reset)
//   dc_dregen_out   one-cycle beat-complete pulse
//   dc_done_out     one-cycle burst-complete pulse
//   dc_err_out      one-cycle timeout pulse
//   dc_busy_out     high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module device_burst_controller #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 15,
  localparam int BL_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [BL_W-1:0]   burst_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dc_cs_out,
  output logic              dc_rd_out,
  output logic              dc_wr_out,
  output logic [ADDR_W-1:0] dc_addr_out,
  output logic [DATA_W-1:0] dc_wdata_out,
  output logic [DATA_W-1:0] dc_rdata_out,
  output logic              dc_dregen_out,
  output logic              dc_done_out,
  output logic              dc_err_out,
  output logic              dc_busy_out
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [BL_W-1:0]   MAX_LEN   = BL_W'(MAX_BURST);
  localparam logic [BL_W-1:0]   ONE_LEN   = {{(BL_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [WC_W-1:0]   ONE_WAIT  = {{(WC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CS     = 3'd1,
    S_ACCESS = 3'd2,
    S_DREGEN = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_wr_mode;
  logic [BL_W-1:0]   r_len;
  logic [BL_W-1:0]   r_beats;
  logic [WC_W-1:0]   r_wait;
  logic [BL_W-1:0]   w_len;

  // Effective burst length: zero means one beat, oversize clamps to MAX_BURST.
  always_comb begin
    w_len = ONE_LEN;
    if (burst_len == {BL_W{1'b0}}) begin
      w_len = ONE_LEN;
    end else if (burst_len > MAX_LEN) begin
      w_len = MAX_LEN;
    end else begin
      w_len = burst_len;
    end
  end

  // Burst FSM. Each output register is loaded with the value of the state
  // being entered, so the outputs line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_mode     <= 1'b0;
      r_len         <= {BL_W{1'b0}};
      r_beats       <= {BL_W{1'b0}};
      r_wait        <= {WC_W{1'b0}};
      dc_cs_out     <= 1'b1;
      dc_rd_out     <= 1'b0;
      dc_wr_out     <= 1'b0;
      dc_addr_out   <= {ADDR_W{1'b0}};
      dc_wdata_out  <= {DATA_W{1'b0}};
      dc_rdata_out  <= {DATA_W{1'b0}};
      dc_dregen_out <= 1'b0;
      dc_done_out   <= 1'b0;
      dc_err_out    <= 1'b0;
      dc_busy_out   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      dc_dregen_out <= 1'b0;
      dc_done_out   <= 1'b0;
      dc_err_out    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_en) begin
            r_wr_mode   <= wr_en;
            r_len       <= w_len;
            r_beats     <= {BL_W{1'b0}};
            dc_addr_out <= start_addr;
            dc_cs_out   <= 1'b0;
            dc_busy_out <= 1'b1;
            r_state     <= S_CS;
          end
        end
        S_CS: begin
          dc_rd_out    <= ~r_wr_mode;
          dc_wr_out    <= r_wr_mode;
          dc_wdata_out <= wr_data;
          r_wait       <= {WC_W{1'b0}};
          r_state      <= S_ACCESS;
        end
        S_ACCESS: begin
          // mem_ready takes priority over the timeout on the last wait cycle.
          if (mem_ready) begin
            dc_rd_out     <= 1'b0;
            dc_wr_out     <= 1'b0;
            if (!r_wr_mode) begin
              dc_rdata_out <= mem_rdata;
            end
            dc_dregen_out <= 1'b1;
            r_beats       <= r_beats + ONE_LEN;
            r_state       <= S_DREGEN;
          end else if (r_wait == WAIT_LAST) begin
            dc_rd_out  <= 1'b0;
            dc_wr_out  <= 1'b0;
            dc_cs_out  <= 1'b1;
            dc_err_out <= 1'b1;
            r_state    <= S_ERR;
          end else begin
            r_wait <= r_wait + ONE_WAIT;
          end
        end
        S_DREGEN: begin
          // r_beats already counts the beat that just completed.
          if (r_beats < r_len) begin
            dc_addr_out  <= dc_addr_out + ONE_ADDR;
            dc_wdata_out <= wr_data;
            dc_rd_out    <= ~r_wr_mode;
            dc_wr_out    <= r_wr_mode;
            r_wait       <= {WC_W{1'b0}};
            r_state      <= S_ACCESS;
          end else begin
            dc_cs_out   <= 1'b1;
            dc_done_out <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE, S_ERR: begin
          // Return to idle output values; read data is deliberately kept.
          dc_addr_out  <= {ADDR_W{1'b0}};
          dc_wdata_out <= {DATA_W{1'b0}};
          dc_busy_out  <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          dc_cs_out    <= 1'b1;
          dc_rd_out    <= 1'b0;
          dc_wr_out    <= 1'b0;
          dc_addr_out  <= {ADDR_W{1'b0}};
          dc_wdata_out <= {DATA_W{1'b0}};
          dc_busy_out  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
